apb3_rr_arbiter: RTL
====================

APB3_RR_ARBITER -- requirements
Module: apb3_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of APB3 requester ports (>=1).
REQ-002 Parameter ADDR_WIDTH, default 32: paddr width.
REQ-003 Parameter DATA_WIDTH, default 32: pwdata/prdata width.
REQ-004 Parameter TIMEOUT, default 0: max ACCESS cycles before an error completion; 0 disables the timeout.
REQ-005 The ports SHALL be as follows; one clock; reset is synchronous and active-high.
- pclk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- req_paddr  in  NUM_REQ x ADDR_WIDTH  requester addresses
- req_psel  in  NUM_REQ  requester selects; a high bit is a request
- req_penable  in  NUM_REQ  requester enables
- req_pwrite  in  NUM_REQ  requester directions
- req_pwdata  in  NUM_REQ x DATA_WIDTH  requester write data
- req_prdata  out  NUM_REQ x DATA_WIDTH  read data returned to requesters
- req_pready  out  NUM_REQ  transfer complete, per requester
- req_pslverr  out  NUM_REQ  error, per requester
- cmp_paddr / cmp_pwrite / cmp_pwdata  out  ADDR_WIDTH / 1 / DATA_WIDTH  completer request
- cmp_psel / cmp_penable  out  1 / 1  completer select and enable
- cmp_prdata / cmp_pready / cmp_pslverr  in  DATA_WIDTH / 1 / 1  completer response
- grant  out  NUM_REQ  one-hot granted requester, all zero when idle
- busy  out  1  high in SETUP or ACCESS

Function
REQ-006 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-007 In IDLE with any req_psel high, the arbiter SHALL pick a winner and register grant, cmp_paddr, cmp_pwrite and cmp_pwdata, then enter SETUP on the next edge. Otherwise it stays in IDLE.
REQ-008 Winner selection SHALL be round-robin: search ascending from index ptr, wrapping at NUM_REQ; the first set req_psel bit wins.
REQ-009 In SETUP the block SHALL drive cmp_psel=1 and cmp_penable=0, then enter ACCESS unconditionally.
REQ-010 In ACCESS the block SHALL drive cmp_psel=1 and cmp_penable=1 and hold all completer request fields stable.
REQ-011 In the ACCESS cycle where cmp_pready=1:
- req_pready[g]=1, req_prdata[g]=cmp_prdata, req_pslverr[g]=cmp_pslverr for that cycle only (combinational);
- ptr SHALL become (g+1) mod NUM_REQ;
- state SHALL return to IDLE.
REQ-012 Non-granted requesters SHALL see req_pready=0, req_pslverr=0 and req_prdata=0 at all times. They wait without loss of request.
REQ-013 Minimum transfer latency SHALL be 3 cycles from request seen in IDLE to req_pready (IDLE, SETUP, ACCESS), plus completer wait states.
REQ-014 With TIMEOUT>0, a counter SHALL clear on SETUP and increment each ACCESS cycle without cmp_pready. If cmp_pready=0 in the ACCESS cycle where the counter equals TIMEOUT-1, the block SHALL drive req_pready[g]=1, req_pslverr[g]=1 and req_prdata[g]=0, then return to IDLE. If cmp_pready=1 in that same cycle, the normal response SHALL win.
REQ-015 If the granted requester drops req_psel before completion, the completer transfer SHALL still finish with the latched fields. The response is discarded and ptr still advances.
REQ-016 With NUM_REQ=1, ptr SHALL stay 0 and the block SHALL behave as a registered pass-through with a 1-cycle arbitration overhead.
REQ-017 Index and ptr width SHALL be max(1,$clog2(NUM_REQ)). The counter width SHALL be max(1,$clog2(TIMEOUT+1)).

Reset
REQ-018 On rst=1 at a clock edge the block SHALL set:
- state IDLE, ptr 0, counter 0;
- grant 0, busy 0;
- cmp_psel, cmp_penable, cmp_paddr, cmp_pwrite, cmp_pwdata all 0.
REQ-019 Reset during SETUP or ACCESS SHALL abort the transfer: cmp_psel is low from the next cycle, and no req_pready is issued for the aborted transfer.

Structure
REQ-020 Package apb3_arb_pkg SHALL hold the state enum type and the index-width helper function.
REQ-021 Round-robin selection SHALL be a combinational sub-module apb3_rr_pick with inputs request vector and ptr, and outputs one-hot grant, index and valid.

Verification
REQ-022 Single request: NUM_REQ=2, req_psel[0] write 0x1000/0xA5A5A5A5, completer ready on the first ACCESS cycle -> cmp_psel in cycles 1-2, penable in cycle 2, req_pready[0] in cycle 2, req_pready[1] stays 0.
REQ-023 Contention: req_psel[0] and req_psel[1] high simultaneously with ptr=0 -> requester 0 served first, then requester 1; no cycle with both grant bits set.
REQ-024 Fairness: NUM_REQ=4, all requesters continuously requesting for 8 transfers -> grant order 0,1,2,3,0,1,2,3.
REQ-025 Wait states and error: completer holds pready=0 for 5 cycles, then pready=1 with pslverr=1 and prdata=0xDEADBEEF -> req_pslverr=1 and data forwarded in that cycle only; completer fields stable throughout.
REQ-026 Timeout: TIMEOUT=4, completer never ready -> req_pready=1 and req_pslverr=1 on the 4th ACCESS cycle; cmp_psel low the next cycle.
REQ-027 Reset mid-ACCESS: rst pulsed in the 2nd ACCESS cycle -> all outputs 0 the next cycle, ptr 0, and no req_pready issued.

Source files
------------

// File: rtl/apb3_arb_pkg.sv
// apb3_arb_pkg: arbiter state type and index-width helper
package apb3_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/apb3_rr_pick.sv
// apb3_rr_pick: combinational round-robin winner search starting at ptr
module apb3_rr_pick
    import apb3_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);
    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    // Rotate so bit 0 is the ptr requester; the lowest set bit is then the winner.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = IW'(i);
        sum = {1'b0, ptr} + {1'b0, off};
        idx = IW'((sum >= (IW + 1)'(N)) ? sum - (IW + 1)'(N) : sum);
        valid = |req;
        gnt = valid ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/apb3_rr_arbiter.sv
// apb3_rr_arbiter: round-robin arbiter muxing NUM_REQ APB3 requesters onto one completer
module apb3_rr_arbiter
    import apb3_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                                pclk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_paddr,
    input  logic [NUM_REQ-1:0]                  req_psel,
    input  logic [NUM_REQ-1:0]                  req_penable,
    input  logic [NUM_REQ-1:0]                  req_pwrite,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_pwdata,
    output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_prdata,
    output logic [NUM_REQ-1:0]                  req_pready,
    output logic [NUM_REQ-1:0]                  req_pslverr,
    output logic [ADDR_WIDTH-1:0]               cmp_paddr,
    output logic                                cmp_pwrite,
    output logic [DATA_WIDTH-1:0]               cmp_pwdata,
    output logic                                cmp_psel,
    output logic                                cmp_penable,
    input  logic [DATA_WIDTH-1:0]               cmp_prdata,
    input  logic                                cmp_pready,
    input  logic                                cmp_pslverr,
    output logic [NUM_REQ-1:0]                  grant,
    output logic                                busy
);
    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = idx_width(TIMEOUT + 1);

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      pick_idx;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] hit;
    logic               pick_valid;
    logic               timed_out;
    logic               done;

    apb3_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (req_psel),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign cmp_psel    = state != IDLE;
    assign cmp_penable = state == ACCESS;
    assign busy        = cmp_psel;
    assign timed_out   = (TIMEOUT > 0) && cmp_penable && !cmp_pready && (int'(cnt) == TIMEOUT - 1);
    assign done        = cmp_penable && (cmp_pready || timed_out);

    // A requester that has left its access phase gets no response; the transfer still completes.
    assign hit         = {NUM_REQ{done}} & grant & req_psel & req_penable;
    assign req_pready  = hit;
    assign req_pslverr = hit & {NUM_REQ{!cmp_pready || cmp_pslverr}};

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            req_prdata[i] = (hit[i] && cmp_pready) ? cmp_prdata : '0;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gidx       <= '0;
            cnt        <= '0;
            grant      <= '0;
            cmp_paddr  <= '0;
            cmp_pwrite <= 1'b0;
            cmp_pwdata <= '0;
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    state      <= SETUP;
                    grant      <= pick_gnt;
                    gidx       <= pick_idx;
                    cmp_paddr  <= req_paddr[pick_idx];
                    cmp_pwrite <= req_pwrite[pick_idx];
                    cmp_pwdata <= req_pwdata[pick_idx];
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= '0;
                end
                ACCESS: if (done) begin
                    state <= IDLE;
                    grant <= '0;
                    cnt   <= '0;
                    ptr   <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                end else if (TIMEOUT > 0) begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
